aes_round_ctrl: RTL and testbench
=================================

# aes_round_ctrl

Round sequencer for the iterative AES cipher core. Accepts one 128-bit block job, steps the shared round datapath (SubBytes unit, `aes_shift_rows`, MixColumns, AddRoundKey) through the initial key addition plus 10/12/14 rounds, and holds the result until the consumer takes it. It drives the state-register write enable and mux select, the ShiftRows direction (`op_i` to `aes_shift_rows`), the MixColumns bypass and the round index. It performs req/ack handshakes with the multi-cycle masked S-box and with the key-expansion unit.

## Interface
- `RND_W`, 4, round counter width; must be ≥ 4.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `in_valid_i`  in  1  job request.
- `in_ready_o`  out  1  controller idle, job accepted on `in_valid_i & in_ready_o`.
- `op_i`  in  2  2'b01 encrypt, 2'b10 decrypt, others illegal; sampled at accept.
- `key_len_i`  in  2  0: AES-128 (Nr=10), 1: AES-192 (Nr=12), 2: AES-256 (Nr=14), 3: treated as 0; sampled at accept.
- `sub_req_o` / `sub_ack_i`  out/in  1  S-box layer start/done.
- `key_req_o` / `key_ack_i`  out/in  1  round-key request/valid.
- `state_we_o`  out  1  state register write strobe.
- `state_sel_o`  out  2  0: hold, 1: input ^ key, 2: full-round result, 3: final-round result.
- `shift_op_o`  out  2  ShiftRows direction, equal to latched op.
- `mix_bypass_o`  out  1  MixColumns bypass for the final round.
- `round_o`  out  RND_W  current round index.
- `out_valid_o` / `out_ready_i`  out/in  1  result handshake.
- `busy_o`  out  1  not in IDLE.
- `err_o`  out  1  one-cycle pulse on an illegal-op accept.
- `state_clear_o`  out  1  state scrub strobe. Tied to 0 when the feature is compiled out.

## Operation
- States are IDLE, INIT, SUB, KEY, DONE, and CLEAR (CLEAR exists only with the macro). Reset state is IDLE.
- IDLE:
  - `in_ready_o` = 1.
  - On accept with a legal op: latch op and Nr, set round = 0, go to INIT.
  - On accept with an illegal op: pulse `err_o` the next cycle and stay in IDLE. No other output moves.
- INIT:
  - `key_req_o` = 1 until `key_ack_i`.
  - In the ack cycle: `state_we_o` = 1, `state_sel_o` = 1, round ← 1, go to SUB.
- SUB:
  - `sub_req_o` = 1 until `sub_ack_i`, then go to KEY.
- KEY:
  - `key_req_o` = 1.
  - In the ack cycle: `state_we_o` = 1.
  - If round < Nr: `state_sel_o` = 2, round ← round+1, go to SUB.
  - If round = Nr: `state_sel_o` = 3, `mix_bypass_o` = 1, go to DONE.
  - `mix_bypass_o` is also asserted throughout KEY whenever round = Nr.
- DONE:
  - `out_valid_o` = 1 until `out_ready_i`.
  - On the handshake, go to CLEAR (macro defined) or IDLE.
- `sub_ack_i` and `key_ack_i` are ignored unless the matching req is high.
- `state_we_o` is only ever 1 together with a nonzero `state_sel_o`. In all other cycles `state_sel_o` = 0.
- `shift_op_o` holds the latched op from accept until the next accept.
- `in_valid_i` is ignored outside IDLE; no queueing.

## Timing
- Reset values:
  - `in_ready_o` = 1 (IDLE).
  - All other outputs 0, including `round_o`, `shift_op_o`, and `err_o`.
- A reset mid-job aborts at the next edge. Nothing is written, and no `out_valid_o` is produced for the aborted job.
- Latency with acks arriving in the same cycle as the req (zero-wait):
  - Accept edge t; INIT at t+1; round r SUB at t+2r, KEY at t+2r+1.
  - DONE at t+2Nr+2, so `out_valid_o` first rises 22/26/30 cycles after accept for AES-128/192/256.
  - Each wait cycle on an ack adds exactly one cycle.
- `out_valid_o` is held stable until taken. With `out_ready_i` already high, DONE lasts one cycle.
- Back-to-back jobs:
  - Without the macro, `in_ready_o` rises the cycle after the output handshake.
  - With the macro, it rises one cycle later, after CLEAR.
- `err_o` stays 0 for legal jobs.

## Configuration
- `AES_CTRL_STATE_CLEAR_EN`
  - Defined: after the output handshake the FSM spends exactly one cycle in CLEAR with `state_clear_o` = 1 and `busy_o` = 1, then returns to IDLE.
  - Undefined: the CLEAR state is absent, `state_clear_o` is constant 0, and DONE returns directly to IDLE.

## Test plan
- AES-128 encrypt, `op_i` = 01, acks zero-wait, `out_ready_i` = 1 → `out_valid_o` 22 cycles after accept, 11 `state_we_o` pulses (sel 1, 2×9, 3), `shift_op_o` = 01 throughout, `mix_bypass_o` only in round 10.
- AES-256 decrypt, `op_i` = 10, `sub_ack_i` delayed 3 cycles every round → `round_o` steps 1..14, `out_valid_o` at 30 + 14·3 = 72 cycles, `shift_op_o` = 10.
- Illegal `op_i` = 00 and 11 → `err_o` one-cycle pulse, `busy_o` stays 0, no req or write strobes.
- `out_ready_i` held low for 5 cycles in DONE → `out_valid_o` stays high and stable, `in_ready_o` = 0, no extra writes. A second `in_valid_i` is ignored until IDLE.
- `rst_i` asserted during round 5 → next cycle IDLE, all outputs at reset values. A fresh AES-192 job then completes in 26 cycles.
- Macro on vs off → `state_clear_o` one-cycle pulse after the handshake versus never, and `in_ready_o` returns at +2 versus +1 cycles.

Source files
------------

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES core: walks the shared round datapath through
// key addition plus Nr rounds. Optional post-job state scrub via AES_CTRL_STATE_CLEAR_EN.
module aes_round_ctrl #(
    parameter int RND_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [1:0]       op_i,
    input  logic [1:0]       key_len_i,
    output logic             sub_req_o,
    input  logic             sub_ack_i,
    output logic             key_req_o,
    input  logic             key_ack_i,
    output logic             state_we_o,
    output logic [1:0]       state_sel_o,
    output logic [1:0]       shift_op_o,
    output logic             mix_bypass_o,
    output logic [RND_W-1:0] round_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             busy_o,
    output logic             err_o,
    output logic             state_clear_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SUB,
        S_KEY,
`ifdef AES_CTRL_STATE_CLEAR_EN
        S_CLEAR,
`endif
        S_DONE
    } state_t;

    state_t           state_reg, state_next;
    logic [1:0]       op_reg;
    logic [RND_W-1:0] nr_reg;
    logic [RND_W-1:0] round_reg;
    logic             err_reg;

    logic             accept;
    logic             op_legal;
    logic             last_round;
    logic [RND_W-1:0] nr_sel;

    assign accept     = in_valid_i && (state_reg == S_IDLE);
    assign op_legal   = (op_i == 2'b01) || (op_i == 2'b10);
    assign last_round = (round_reg == nr_reg);

    // key_len 3 is folded onto AES-128
    always_comb begin
        case (key_len_i)
            2'd1:    nr_sel = RND_W'(12);
            2'd2:    nr_sel = RND_W'(14);
            default: nr_sel = RND_W'(10);
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (accept && op_legal) state_next = S_INIT;
            S_INIT: if (key_ack_i) state_next = S_SUB;
            S_SUB:  if (sub_ack_i) state_next = S_KEY;
            S_KEY:  if (key_ack_i) state_next = last_round ? S_DONE : S_SUB;
`ifdef AES_CTRL_STATE_CLEAR_EN
            S_DONE:  if (out_ready_i) state_next = S_CLEAR;
            S_CLEAR: state_next = S_IDLE;
`else
            S_DONE:  if (out_ready_i) state_next = S_IDLE;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    // Job context; an illegal op only raises the error pulse and touches nothing else
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_reg    <= 2'b00;
            nr_reg    <= '0;
            round_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            err_reg <= accept && !op_legal;
            if (accept && op_legal) begin
                op_reg    <= op_i;
                nr_reg    <= nr_sel;
                round_reg <= '0;
            end else if (state_reg == S_INIT && key_ack_i) begin
                round_reg <= RND_W'(1);
            end else if (state_reg == S_KEY && key_ack_i && !last_round) begin
                round_reg <= round_reg + 1'b1;
            end
        end
    end

    always_comb begin
        in_ready_o    = 1'b0;
        sub_req_o     = 1'b0;
        key_req_o     = 1'b0;
        state_we_o    = 1'b0;
        state_sel_o   = 2'd0;
        mix_bypass_o  = 1'b0;
        out_valid_o   = 1'b0;
        state_clear_o = 1'b0;
        case (state_reg)
            S_IDLE: in_ready_o = 1'b1;
            S_INIT: begin
                key_req_o = 1'b1;
                if (key_ack_i) begin
                    state_we_o  = 1'b1;
                    state_sel_o = 2'd1;
                end
            end
            S_SUB: sub_req_o = 1'b1;
            S_KEY: begin
                key_req_o    = 1'b1;
                mix_bypass_o = last_round;
                if (key_ack_i) begin
                    state_we_o  = 1'b1;
                    state_sel_o = last_round ? 2'd3 : 2'd2;
                end
            end
            S_DONE: out_valid_o = 1'b1;
`ifdef AES_CTRL_STATE_CLEAR_EN
            S_CLEAR: state_clear_o = 1'b1;
`endif
            default: in_ready_o = 1'b0;
        endcase
    end

    assign busy_o     = (state_reg != S_IDLE);
    assign err_o      = err_reg;
    assign shift_op_o = op_reg;
    assign round_o    = round_reg;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: table jobs plus random jobs against a job-level model
// (latency = 2*Nr + 2 + inserted waits, Nr+1 writes), illegal-op and mid-job reset sequences.
module tb_aes_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [1:0] op = 2'b00;
    logic [1:0] key_len = 2'b00;
    logic       sub_ack = 1'b0;
    logic       key_ack = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready, sub_req, key_req, state_we, mix, out_valid, busy, err, state_clear;
    logic [1:0] state_sel, shift_op;
    logic [3:0] round;

    int checks = 0;
    int errors = 0;
    logic [1:0] last_op = 2'b00;

    aes_round_ctrl #(.RND_W(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .key_len_i(key_len),
        .sub_req_o(sub_req), .sub_ack_i(sub_ack),
        .key_req_o(key_req), .key_ack_i(key_ack),
        .state_we_o(state_we), .state_sel_o(state_sel),
        .shift_op_o(shift_op), .mix_bypass_o(mix), .round_o(round),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .busy_o(busy), .err_o(err), .state_clear_o(state_clear)
    );

    typedef struct {
        logic [1:0] op;
        logic [1:0] kl;
        int         sw;   // fixed S-box wait per request, -1 = random
        int         kw;   // fixed key wait per request, -1 = random
        int         rw;   // cycles out_ready stays low in DONE
        int         lat;  // hand-derived latency, -1 = use model
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input logic [1:0] jop, input logic [1:0] jkl, input int sw,
                           input int kw, input int rw, input int lat_tab);
        int nr, cyc, waits, nwr, nmix, last_kw, sub_left, key_left, rdy_left, vcyc;
        int bad_wr, bad_mix, bad_misc, bad_hold, exp_lat;
        bit sub_act, key_act, seen_v, hs;
        logic [1:0] exp_sel;
        nr = (jkl == 2'd2) ? 14 : (jkl == 2'd1) ? 12 : 10;
        cyc = 0; waits = 0; nwr = 0; nmix = 0; last_kw = 0; sub_left = 0; key_left = 0;
        rdy_left = 0; vcyc = 0; bad_wr = 0; bad_mix = 0; bad_misc = 0; bad_hold = 0;
        sub_act = 0; key_act = 0; seen_v = 0; hs = 0;
        @(negedge clk);
        chk("start_ready", in_ready, 1);
        in_valid = 1'b1; op = jop; key_len = jkl;
        sub_ack = 1'b0; key_ack = 1'b0; out_ready = 1'b0;
        while (!hs && cyc < 400) begin
            @(negedge clk);
            cyc++;
            in_valid = busy ? 1'($urandom % 2) : 1'b0;
            op = 2'($urandom);
            key_len = 2'($urandom);
            if (sub_req) begin
                if (!sub_act) begin
                    sub_act = 1;
                    sub_left = (sw < 0) ? int'($urandom_range(0, 3)) : sw;
                    waits += sub_left;
                end
                sub_ack = (sub_left == 0);
                if (sub_left == 0) sub_act = 0; else sub_left--;
            end else begin
                sub_ack = 1'($urandom % 2);
            end
            if (key_req) begin
                if (!key_act) begin
                    key_act = 1;
                    key_left = (kw < 0) ? int'($urandom_range(0, 3)) : kw;
                    last_kw = key_left;
                    waits += key_left;
                end
                key_ack = (key_left == 0);
                if (key_left == 0) key_act = 0; else key_left--;
            end else begin
                key_ack = 1'($urandom % 2);
            end
            if (out_valid) begin
                if (!seen_v) begin
                    seen_v = 1;
                    vcyc = cyc;
                    rdy_left = rw;
                end
                if (in_ready) bad_hold++;
                out_ready = (rdy_left == 0);
                if (rdy_left > 0) rdy_left--;
            end else begin
                if (seen_v) bad_hold++;
                out_ready = 1'($urandom % 2);
            end
            #1;
            if (state_we) begin
                exp_sel = (nwr == 0) ? 2'd1 : (nwr == nr) ? 2'd3 : 2'd2;
                if (state_sel !== exp_sel || int'(round) != nwr) bad_wr++;
                nwr++;
            end else if (state_sel !== 2'd0) begin
                bad_wr++;
            end
            if (mix) begin
                nmix++;
                if (!key_req || int'(round) != nr) bad_mix++;
            end
            if (shift_op !== jop || err !== 1'b0) bad_misc++;
            if (out_valid && out_ready) hs = 1;
        end
        exp_lat = (lat_tab >= 0) ? lat_tab : 2 * nr + 2 + waits;
        chk("handshake", hs, 1);
        chk("latency", vcyc, exp_lat);
        chk("writes", nwr, nr + 1);
        chk("write_sel_round", bad_wr, 0);
        chk("mix_count", nmix, last_kw + 1);
        chk("mix_place", bad_mix, 0);
        chk("shift_err", bad_misc, 0);
        chk("valid_hold", bad_hold, 0);
        if (!hs) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            in_valid = 1'b0; sub_ack = 1'b0; key_ack = 1'b0; out_ready = 1'b0;
            last_op = 2'b00;
        end else begin
            @(negedge clk);
            in_valid = 1'b0; sub_ack = 1'b0; key_ack = 1'b0; out_ready = 1'b0;
            #1;
`ifdef AES_CTRL_STATE_CLEAR_EN
            chk("clear_pulse", state_clear, 1);
            chk("clear_busy", busy, 1);
            chk("clear_ready", in_ready, 0);
            @(negedge clk);
            #1;
`endif
            chk("ready_back", in_ready, 1);
            chk("clear_off", state_clear, 0);
            last_op = jop;
        end
        $display("job op=%b key_len=%0d nr=%0d latency=%0d expected=%0d writes=%0d",
                 jop, jkl, nr, vcyc, exp_lat, nwr);
    endtask

    task automatic illegal(input logic [1:0] bop);
        @(negedge clk);
        in_valid = 1'b1; op = bop;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("err_pulse", err, 1);
        chk("err_busy", busy, 0);
        chk("err_ready", in_ready, 1);
        chk("err_quiet", {sub_req, key_req, state_we, state_sel, out_valid, mix}, 0);
        chk("err_shift", shift_op, last_op);
        @(negedge clk);
        #1;
        chk("err_clear", err, 0);
        chk("err_busy2", busy, 0);
        $display("illegal op=%b err pulse checked", bop);
    endtask

    task automatic reset_mid_job();
        bit hit;
        hit = 0;
        @(negedge clk);
        in_valid = 1'b1; op = 2'b01; key_len = 2'd0;
        for (int i = 0; i < 100 && !hit; i++) begin
            @(negedge clk);
            in_valid = 1'b0; sub_ack = 1'b1; key_ack = 1'b1;
            #1;
            if (round == 4'd5) hit = 1;
        end
        chk("reached_round5", round, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; sub_ack = 1'b0; key_ack = 1'b0;
        #1;
        chk("abort_ready", in_ready, 1);
        chk("abort_busy", busy, 0);
        chk("abort_round", round, 0);
        chk("abort_shift", shift_op, 0);
        chk("abort_quiet", {sub_req, key_req, state_we, state_sel, mix, out_valid, err, state_clear}, 0);
        last_op = 2'b00;
        $display("reset during round 5 checked");
    endtask

    initial begin
        vecs[0] = '{2'b01, 2'd0, 0, 0, 0, 22};
        vecs[1] = '{2'b10, 2'd2, 3, 0, 0, 72};
        vecs[2] = '{2'b01, 2'd1, 0, 0, 5, 26};
        vecs[3] = '{2'b10, 2'd3, 0, 1, 2, 33};
        vecs[4] = '{2'b01, 2'd2, 1, 1, 0, 59};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_round", round, 0);
        chk("rst_shift", shift_op, 0);
        chk("rst_others", {sub_req, key_req, state_we, state_sel, mix, out_valid, err, state_clear}, 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_job(vecs[i].op, vecs[i].kl, vecs[i].sw, vecs[i].kw, vecs[i].rw, vecs[i].lat);

        illegal(2'b00);
        illegal(2'b11);

        for (int i = 0; i < 6; i++)
            run_job(($urandom % 2) ? 2'b01 : 2'b10, 2'($urandom), -1, -1,
                    int'($urandom_range(0, 4)), -1);

        reset_mid_job();
        run_job(2'b01, 2'd1, 0, 0, 0, 26);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
